// File: rtl/clint_pkg.sv
// ---------------------------------------------------------------------------
// clint_pkg
// Shared definitions for the CLINT bus-side controller:
//   - bus/register widths
//   - memory-mapped byte offsets of the four 32-bit timer words
//   - controller FSM state encoding
//   - staging-register tag (which 64-bit register a staged lo word belongs to)
// ---------------------------------------------------------------------------
package clint_pkg;

  localparam int BUS_W = 32;
  localparam int REG_W = 64;

  localparam logic [3:0] MTIME_LO    = 4'h0;
  localparam logic [3:0] MTIME_HI    = 4'h4;
  localparam logic [3:0] MTIMECMP_LO = 4'h8;
  localparam logic [3:0] MTIMECMP_HI = 4'hC;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    TAG_MTIME    = 1'b0,
    TAG_MTIMECMP = 1'b1
  } tag_e;

endpackage

// File: rtl/clint_ctrl_if.sv
// ---------------------------------------------------------------------------
// clint_ctrl_if
// Simple req/ack MMIO bus between the core's decode and clint_ctrl.
//   i_req   : request, held high by the master until it sees o_ack
//   i_we    : 1 = write, 0 = read
//   i_addr  : byte offset inside the CLINT timer window
//   i_wdata : write data
//   o_ack   : one-cycle response strobe
//   o_err   : misaligned access, valid with o_ack
//   o_rdata : read data, valid with o_ack
//
// Handshake: a transfer is accepted on the first clock edge where the slave
// is idle and i_req is high; i_we/i_addr/i_wdata must be stable from then
// until o_ack. The master drops i_req in the o_ack cycle; a request still
// high in the following cycle is a new transfer.
// ---------------------------------------------------------------------------
interface clint_ctrl_if #(
  parameter int BUS_WIDTH = 32
) ();
  logic                 i_req;
  logic                 i_we;
  logic [3:0]           i_addr;
  logic [BUS_WIDTH-1:0] i_wdata;
  logic                 o_ack;
  logic                 o_err;
  logic [BUS_WIDTH-1:0] o_rdata;

  modport master (
    output i_req, i_we, i_addr, i_wdata,
    input  o_ack, o_err, o_rdata
  );

  modport slave (
    input  i_req, i_we, i_addr, i_wdata,
    output o_ack, o_err, o_rdata
  );
endinterface

// File: rtl/clint_ctrl.sv
// ---------------------------------------------------------------------------
// clint_ctrl
// Bus-side controller for the CLINT timer datapath. Maps mtime/mtimecmp as
// four 32-bit words, turns lo+hi writes into one atomic 64-bit load, gives
// tear-free 64-bit mtime reads via a hi-word snapshot, and masks the timer
// interrupt while a mtimecmp update is half written.
// Ports:
//   clk, arstn     : clock, asynchronous active-low reset
//   bus            : req/ack MMIO slave (see clint_ctrl_if)
//   i_mtime        : live mtime from the datapath
//   i_timer_int    : raw datapath compare (mtime >= mtimecmp)
//   o_write_en_1   : mtime load strobe (one cycle, COMMIT only)
//   o_write_en_2   : mtimecmp load strobe (one cycle, COMMIT only)
//   o_data         : 64-bit load data, zero outside COMMIT
//   o_irq          : registered, masked machine timer interrupt
//   o_state        : current FSM state, for observation
// ---------------------------------------------------------------------------
module clint_ctrl
  import clint_pkg::*;
#(
  parameter int REG_WIDTH = 64,  // must equal 2 * BUS_WIDTH
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 arstn,
  clint_ctrl_if.slave          bus,
  input  logic [REG_WIDTH-1:0] i_mtime,
  input  logic                 i_timer_int,
  output logic                 o_write_en_1,
  output logic                 o_write_en_2,
  output logic [REG_WIDTH-1:0] o_data,
  output logic                 o_irq,
  output state_e               o_state
);

  state_e               r_state;
  state_e               w_next;

  // Hi-write request captured at acceptance, consumed in COMMIT.
  tag_e                 r_tgt;
  logic [BUS_WIDTH-1:0] r_hi_wdata;

  // Response registered at acceptance, presented in RESP.
  logic [BUS_WIDTH-1:0] r_rdata;
  logic                 r_err;

  // Lo-word staging for split writes.
  logic [BUS_WIDTH-1:0] r_stage_data;
  logic                 r_stage_valid;
  tag_e                 r_stage_tag;

  // mtime hi snapshot taken on a mtime_lo read.
  logic [BUS_WIDTH-1:0] r_snap;
  logic                 r_snap_valid;

  // Copy of the last committed mtimecmp (datapath has no read port for it).
  logic [REG_WIDTH-1:0] r_shadow_cmp;

  logic                 r_irq;

  logic                 w_accept;
  logic                 w_misaligned;
  logic                 w_stage_hit;
  logic [BUS_WIDTH-1:0] w_low;
  logic                 w_we1;
  logic                 w_we2;
  logic [REG_WIDTH-1:0] w_data;

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_misaligned = (bus.i_addr[1:0] != 2'b00);
    w_stage_hit  = r_stage_valid && (r_stage_tag == r_tgt);
    w_low        = '0;
    w_we1        = 1'b0;
    w_we2        = 1'b0;
    w_data       = '0;
    case (r_state)
      IDLE: begin
        if (bus.i_req) begin
          w_accept = 1'b1;
          // Only an aligned hi-word write needs the extra commit cycle.
          if (!w_misaligned && bus.i_we && bus.i_addr[2])
            w_next = COMMIT;
          else
            w_next = RESP;
        end
      end
      COMMIT: begin
        if (w_stage_hit)
          w_low = r_stage_data;
        else if (r_tgt == TAG_MTIMECMP)
          w_low = r_shadow_cmp[BUS_WIDTH-1:0];
        else
          w_low = i_mtime[BUS_WIDTH-1:0];
        w_data = {r_hi_wdata, w_low};
        w_we1  = (r_tgt == TAG_MTIME);
        w_we2  = (r_tgt == TAG_MTIMECMP);
        w_next = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state       <= IDLE;
      r_tgt         <= TAG_MTIME;
      r_hi_wdata    <= '0;
      r_rdata       <= '0;
      r_err         <= 1'b0;
      r_stage_data  <= '0;
      r_stage_valid <= 1'b0;
      r_stage_tag   <= TAG_MTIME;
      r_snap        <= '0;
      r_snap_valid  <= 1'b0;
      r_shadow_cmp  <= '0;
      r_irq         <= 1'b0;
    end else begin
      r_state <= w_next;
      // Mask only while a mtimecmp lo word is waiting for its hi half.
      r_irq   <= i_timer_int & ~(r_stage_valid & (r_stage_tag == TAG_MTIMECMP));

      if (w_accept) begin
        r_err   <= w_misaligned;
        r_rdata <= '0;
        if (!w_misaligned) begin
          if (bus.i_we) begin
            if (bus.i_addr[2]) begin
              r_tgt      <= bus.i_addr[3] ? TAG_MTIMECMP : TAG_MTIME;
              r_hi_wdata <= bus.i_wdata;
            end else begin
              r_stage_data  <= bus.i_wdata;
              r_stage_valid <= 1'b1;
              r_stage_tag   <= bus.i_addr[3] ? TAG_MTIMECMP : TAG_MTIME;
            end
          end else begin
            case (bus.i_addr)
              MTIME_LO: begin
                r_rdata      <= i_mtime[BUS_WIDTH-1:0];
                r_snap       <= i_mtime[REG_WIDTH-1:BUS_WIDTH];
                r_snap_valid <= 1'b1;
              end
              MTIME_HI: begin
                r_rdata      <= r_snap_valid ? r_snap : i_mtime[REG_WIDTH-1:BUS_WIDTH];
                r_snap_valid <= 1'b0;
              end
              MTIMECMP_LO: r_rdata <= r_shadow_cmp[BUS_WIDTH-1:0];
              MTIMECMP_HI: r_rdata <= r_shadow_cmp[REG_WIDTH-1:BUS_WIDTH];
              default:     r_rdata <= '0;
            endcase
          end
        end
      end

      if (r_state == COMMIT) begin
        // A mismatched tag leaves the staged word for its own hi write.
        if (w_stage_hit)
          r_stage_valid <= 1'b0;
        if (r_tgt == TAG_MTIMECMP)
          r_shadow_cmp <= w_data;
      end
    end
  end

  assign bus.o_ack   = (r_state == RESP);
  assign bus.o_err   = (r_state == RESP) & r_err;
  assign bus.o_rdata = (r_state == RESP) ? r_rdata : '0;
  assign o_write_en_1 = w_we1;
  assign o_write_en_2 = w_we2;
  assign o_data       = w_data;
  assign o_irq        = r_irq;
  assign o_state      = r_state;

endmodule
